// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file round-robin arbiter.
//   DATA_W / ADDR_W : default data and address widths of the shared register file
//   arb_state_t     : arbiter sequencing states
//   arb_req_t       : request captured from the winning requester
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              owner;
    } arb_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser.
//   req0, req1 : request levels
//   last       : requester granted most recently
//   winner     : chosen requester (0 or 1), meaningful when any = 1
//   any        : at least one request is present
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic any
);

    always_comb begin
        any    = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            // On a tie the requester that did not win last time goes next.
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_rr_arbiter.sv
// Round-robin arbiter sharing one register file between two requesters.
// Operations are serialised IDLE -> ISSUE (-> CAPTURE for reads) -> IDLE.
//   clk, resetn          : clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1: requester command inputs
//   gnt0/1               : one-cycle accept pulse (during ISSUE)
//   rvalid0/1, rdata0/1  : read-data return to the owning requester
//   mem_wr/rd/addr/din   : register file command outputs
//   mem_dout, mem_error  : register file responses
//   busy                 : arbiter not in IDLE
//   err_sticky           : mem_error has been observed since reset
module regfile_rr_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_error,
    output logic              busy,
    output logic              err_sticky
);

    import regfile_pkg::*;

    arb_state_t        state_reg;
    arb_req_t          cur_reg;
    arb_req_t          sel_next;
    logic              last_reg;
    logic              winner;
    logic              any_req;

    logic              gnt0_reg, gnt1_reg;
    logic              rvalid0_reg, rvalid1_reg;
    logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
    logic              mem_wr_reg, mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_din_reg;
    logic              busy_reg;
    logic              err_sticky_reg;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_reg),
        .winner (winner),
        .any    (any_req)
    );

    // Command of the requester that would win at this edge.
    always_comb begin
        sel_next.we    = winner ? we1    : we0;
        sel_next.addr  = winner ? addr1  : addr0;
        sel_next.wdata = winner ? wdata1 : wdata0;
        sel_next.owner = winner;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cur_reg        <= '0;
            last_reg       <= 1'b1;   // requester 0 wins the first tie
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
            mem_wr_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
            busy_reg       <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            // Pulses and strobes default low; only the transition that
            // needs them raises them for the following cycle.
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            err_sticky_reg <= err_sticky_reg | mem_error;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        cur_reg      <= sel_next;
                        last_reg     <= winner;
                        gnt0_reg     <= ~winner;
                        gnt1_reg     <= winner;
                        mem_wr_reg   <= sel_next.we;
                        mem_rd_reg   <= ~sel_next.we;
                        mem_addr_reg <= sel_next.addr;
                        mem_din_reg  <= sel_next.wdata;
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A write is committed by the register file at this edge.
                    if (cur_reg.we) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        busy_reg  <= 1'b1;
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // mem_dout now holds the word read during ISSUE.
                    if (cur_reg.owner) begin
                        rdata1_reg  <= mem_dout;
                        rvalid1_reg <= 1'b1;
                    end else begin
                        rdata0_reg  <= mem_dout;
                        rvalid0_reg <= 1'b1;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt0       = gnt0_reg;
    assign gnt1       = gnt1_reg;
    assign rvalid0    = rvalid0_reg;
    assign rvalid1    = rvalid1_reg;
    assign rdata0     = rdata0_reg;
    assign rdata1     = rdata1_reg;
    assign mem_wr     = mem_wr_reg;
    assign mem_rd     = mem_rd_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;
    assign busy       = busy_reg;
    assign err_sticky = err_sticky_reg;

endmodule
